// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter and its picker.
package mux8_rr_arbiter_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned SEL_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Width of the hold counter: enough to count up to the hold limit, never zero.
  function automatic int unsigned hold_cnt_w(input int unsigned max_hold);
    return (max_hold == 0) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Rotate-priority picker: first requesting, non-excluded lane at or after ptr, wrapping 7->0.
module rr_pick8
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] exclude,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] lane;

  // Walk from the farthest offset back to ptr so the nearest candidate wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    lane  = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      lane = ptr + SEL_W'(i);
      if (req[lane] && !exclude[lane]) begin
        found = 1'b1;
        idx   = lane;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 8:1 mux, with a bounded grant hold.
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   din,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [SEL_W-1:0]           sel,
  output logic                       valid,
  output logic [WIDTH-1:0]           dout
);

  localparam int unsigned HC_W    = hold_cnt_w(MAX_HOLD);
  localparam bit          LIMITED = (MAX_HOLD != 0);

  state_t             state_q, state_d;
  logic [HC_W-1:0]    hold_q, hold_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [SEL_W-1:0]   sel_d;
  logic               valid_d;

  logic [NUM_REQ-1:0] excl;
  logic               found;
  logic [SEL_W-1:0]   pick;
  logic               cur_req;

  rr_pick8 u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .exclude (excl),
    .found   (found),
    .idx     (pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      ptr_q   <= '0;
      gnt     <= '0;
      sel     <= '0;
      valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      valid   <= valid_d;
    end
  end

  // The current owner is always excluded from the pick, so "found" means a competitor exists.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt;
    sel_d   = sel;
    valid_d = valid;
    excl    = (state_q == GRANT) ? gnt : '0;
    cur_req = |(req & gnt);

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = NUM_REQ'(1) << pick;
          sel_d   = pick;
          valid_d = 1'b1;
          hold_d  = HC_W'(1);
          ptr_d   = pick + SEL_W'(1);
        end
      end
      GRANT: begin
        if ((!cur_req && found) ||
            (LIMITED && cur_req && hold_q == HC_W'(MAX_HOLD) && found)) begin
          gnt_d   = NUM_REQ'(1) << pick;
          sel_d   = pick;
          valid_d = 1'b1;
          hold_d  = HC_W'(1);
          ptr_d   = pick + SEL_W'(1);
        end else if (!cur_req) begin
          state_d = IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
          hold_d  = '0;
        end else if (hold_q < HC_W'(MAX_HOLD)) begin
          hold_d  = hold_q + HC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [WIDTH-1:0] lane_data [NUM_REQ];

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      lane_data[i] = din[i*int'(WIDTH) +: WIDTH];
    end
  end

  assign dout = valid ? lane_data[sel] : '0;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: a vector table plus rotation, saturation and unlimited-hold sequences.
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst, rst2;
  logic [7:0] req, req2;
  logic [7:0] din;
  logic [7:0] gnt, gnt2;
  logic [2:0] sel, sel2;
  logic       valid, valid2;
  logic       dout, dout2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.WIDTH(1), .MAX_HOLD(4)) u_dut (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt), .sel(sel), .valid(valid), .dout(dout)
  );

  mux8_rr_arbiter #(.WIDTH(1), .MAX_HOLD(0)) u_dut_nolim (
    .clk(clk), .rst(rst2), .req(req2), .din(din),
    .gnt(gnt2), .sel(sel2), .valid(valid2), .dout(dout2)
  );

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       dout;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input int step, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input int step, input logic [7:0] eg,
                            input logic [2:0] es, input logic ev, input logic ed);
    check({tag, ".gnt"},   step, 32'(gnt),   32'(eg));
    check({tag, ".sel"},   step, 32'(sel),   32'(es));
    check({tag, ".valid"}, step, 32'(valid), 32'(ev));
    check({tag, ".dout"},  step, 32'(dout),  32'(ed));
  endtask

  initial begin
    logic [2:0] lane;
    logic [7:0] d;

    // rst, req, din, exp gnt, exp sel, exp valid, exp dout
    vecs[0]  = '{1'b1, 8'h00, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h04, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 8'h04, 8'h00, 8'h04, 3'd2, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 8'h04, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h20, 8'h20, 8'h20, 3'd5, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 8'h22, 8'h02, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'h02, 8'h02, 8'h02, 3'd1, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 8'hFF, 8'h00, 3'd1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h40, 8'h40, 8'h40, 3'd6, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 8'h81, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 8'h81, 8'h01, 8'h80, 3'd7, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'h81, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 8'h81, 8'h01, 8'h80, 3'd7, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 8'h81, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 8'h00, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};

    rst = 1'b1; req = '0; din = '0;
    rst2 = 1'b1; req2 = '0;
    tick();

    // Reset, mid-grant reset, no-bubble handover and the 7->0 wrap.
    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      din = vecs[i].din;
      tick();
      check_main("vec", i, vecs[i].gnt, vecs[i].sel, vecs[i].valid, vecs[i].dout);
    end

    // All lanes requesting: each lane owns the channel for exactly four cycles in order.
    rst = 1'b1; req = '0; tick(); rst = 1'b0;
    req = 8'hFF;
    for (int n = 0; n < 33; n++) begin
      d = 8'($urandom);
      din = d;
      tick();
      lane = 3'((n / 4) % 8);
      check_main("rot", n, 8'(1) << lane, lane, 1'b1, d[lane]);
    end

    // Lone owner keeps the grant past the limit; a newcomer preempts at the next edge.
    rst = 1'b1; req = '0; tick(); rst = 1'b0;
    req = 8'h08; din = 8'h08;
    for (int n = 0; n < 10; n++) begin
      tick();
      check("sat.gnt", n, 32'(gnt), 32'h08);
    end
    req = 8'h48; din = 8'h40;
    tick();
    check_main("preempt", 0, 8'h40, 3'd6, 1'b1, 1'b1);

    // Unlimited hold: lane 0 keeps the grant until it lets go.
    rst2 = 1'b1; tick(); rst2 = 1'b0;
    req2 = 8'h03; din = 8'h01;
    for (int n = 0; n < 50; n++) begin
      tick();
      check("nolim.gnt", n, 32'(gnt2), 32'h01);
    end
    check("nolim.dout", 0, 32'(dout2), 32'h1);
    req2 = 8'h02;
    tick();
    check("nolim.handover.gnt",   0, 32'(gnt2),   32'h02);
    check("nolim.handover.sel",   0, 32'(sel2),   32'd1);
    check("nolim.handover.valid", 0, 32'(valid2), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
